// File: rtl/sens_ultra_echo_timer.sv
`timescale 1ns/1ps
// Purpose: triggers an HC-SR04-class ranger and times the echo pulse in ACLK cycles,
//          with timeout and holdoff handling and single-shot/continuous operation.
// Latency: trig_o from edge N+1 after start at edge N; result/done 3 cycles after echo_i falls
//          (one more cycle when SENS_ULTRA_DIST_CM_EN adds the centimetre multiply stage).
// Backpressure: none; start outside IDLE is dropped, results hold until the next done.
//
// Ports: ACLK/ARESET (async, active high); start pulse and continuous level in;
//        echo_i raw async echo; trig_o, busy, done, sticky timeout, echo_cycles and
//        dist_cm out. Optional feature macro: SENS_ULTRA_DIST_CM_EN (dist_cm = 0 without it).
// The single counter times trigger, echo wait, echo width and holdoff, so
// HOLDOFF_CYCLES and TRIG_CYCLES must also fit in CNT_WIDTH bits.
module sens_ultra_echo_timer #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3800000,
    parameter int HOLDOFF_CYCLES = 6000000,
    parameter int CNT_WIDTH      = 24,
    parameter int CYCLES_PER_CM  = 5800
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 echo_i,
    output logic                 trig_o,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] echo_cycles,
    output logic [15:0]          dist_cm
);

    if (CYCLES_PER_CM < 1 || (64'(1) << CNT_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_param_check
        $error("sens_ultra_echo_timer: CYCLES_PER_CM must be >= 1 and 2**CNT_WIDTH > TIMEOUT_CYCLES");
    end

    localparam logic [CNT_WIDTH-1:0] TRIG_LAST    = CNT_WIDTH'(TRIG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 echo_m;
    logic                 echo_s;
    logic                 echo_d;
    logic                 echo_rise;
    logic                 echo_fall;
    logic                 result_vld;
    logic [CNT_WIDTH-1:0] result_dat;

    // Two-flop synchronizer, plus a delayed copy for edge detection.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo_i;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            cnt        <= '0;
            trig_o     <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            result_vld <= 1'b0;
            result_dat <= '0;
        end else begin
            result_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        state   <= TRIG;
                        trig_o  <= 1'b1;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        cnt     <= '0;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state  <= WAIT_RISE;
                        trig_o <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    // An echo already high here has no rising edge and is ignored.
                    if (echo_rise) begin
                        state <= MEASURE;
                        cnt   <= CNT_WIDTH'(1);
                    end else if (cnt == TIMEOUT_LAST) begin
                        state      <= HOLDOFF;
                        timeout    <= 1'b1;
                        result_dat <= '0;
                        result_vld <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    // A fall on the same cycle the count hits the limit is a valid echo.
                    if (echo_fall) begin
                        state      <= HOLDOFF;
                        result_dat <= cnt;
                        result_vld <= 1'b1;
                        cnt        <= '0;
                    end else if (cnt >= TIMEOUT_MAX) begin
                        state      <= HOLDOFF;
                        timeout    <= 1'b1;
                        result_dat <= TIMEOUT_MAX;
                        result_vld <= 1'b1;
                        cnt        <= '0;
                    end else if (echo_s) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    trig_o <= 1'b0;
                    busy   <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

`ifdef SENS_ULTRA_DIST_CM_EN
    // dist_cm = echo * round(2^24 / CYCLES_PER_CM) >> 24; done and both results
    // move together through this stage.
    localparam int                PW     = CNT_WIDTH + 32;
    localparam logic [31:0]       DIST_K = 32'(((2 ** 24) + (CYCLES_PER_CM / 2)) / CYCLES_PER_CM);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            done        <= 1'b0;
            echo_cycles <= '0;
            dist_cm     <= '0;
        end else begin
            done <= result_vld;
            if (result_vld) begin
                echo_cycles <= result_dat;
                dist_cm     <= 16'((PW'(result_dat) * PW'(DIST_K)) >> 24);
            end
        end
    end
`else
    assign done        = result_vld;
    assign echo_cycles = result_dat;
    assign dist_cm     = '0;
`endif

endmodule

// File: tb/tb_sens_ultra_echo_timer.sv
`timescale 1ns/1ps
module tb_sens_ultra_echo_timer;

    localparam int TRIG = 10;
    localparam int TMO  = 1000;
    localparam int HOLD = 50;
    localparam int CW   = 24;
    localparam int CPM  = 10;
`ifdef SENS_ULTRA_DIST_CM_EN
    localparam int EXTRA   = 1;
    localparam bit DIST_EN = 1'b1;
`else
    localparam int EXTRA   = 0;
    localparam bit DIST_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          start;
    logic          continuous;
    logic          echo_i;
    logic          trig_o;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] echo_cycles;
    logic [15:0]   dist_cm;

    sens_ultra_echo_timer #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_WIDTH      (CW),
        .CYCLES_PER_CM  (CPM)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
        .continuous  (continuous),
        .echo_i      (echo_i),
        .trig_o      (trig_o),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .echo_cycles (echo_cycles),
        .dist_cm     (dist_cm)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int echo;
        bit tmo;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   dones      = 0;
    int   trig_rises = 0;
    int   cyc        = 0;
    int   m_echo     = 0;
    bit   m_tmo      = 1'b0;
    int   trig_hi    = 0;
    bit   trig_prev  = 1'b0;
    bit   done_prev  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference distance: plain integer centimetres from the echo width.
    function automatic int exp_dist(input int e);
        return DIST_EN ? (e / CPM) : 0;
    endfunction

    always @(posedge ACLK) cyc++;

    // Monitor: trigger widths/counts and scoreboard pops on every done.
    always @(negedge ACLK) begin
        if (ARESET) begin
            trig_hi   = 0;
            trig_prev = 1'b0;
            done_prev = 1'b0;
            m_echo    = 0;
            m_tmo     = 1'b0;
        end else begin
            if (trig_o && !trig_prev) trig_rises++;
            if (trig_o) trig_hi++;
            else if (trig_hi != 0) begin
                check("trig_width", trig_hi, TRIG);
                trig_hi = 0;
            end
            trig_prev = trig_o;
            if (done) begin
                dones++;
                check("done_single_cycle", int'(done_prev), 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("echo_cycles", int'(echo_cycles), e.echo);
                    check("timeout_flag", int'(timeout), int'(e.tmo));
                    check("dist_cm", int'(dist_cm), exp_dist(e.echo));
                    m_echo = e.echo;
                    m_tmo  = e.tmo;
                end
            end
            done_prev = done;
        end
    end

    task automatic wait_trig(input logic lvl, input int lim, input string nm);
        int n = 0;
        while (trig_o !== lvl && n < lim) begin
            @(negedge ACLK);
            n++;
        end
        if (trig_o !== lvl) check(nm, int'(trig_o), int'(lvl));
    endtask

    task automatic wait_busy_low(input int lim);
        int n = 0;
        while (busy !== 1'b0 && n < lim) begin
            @(negedge ACLK);
            n++;
        end
        if (busy !== 1'b0) check("busy_drop_wait", int'(busy), 0);
    endtask

    task automatic idle_checks();
        check("idle_busy", int'(busy), 0);
        check("hold_timeout", int'(timeout), int'(m_tmo));
        check("hold_echo_cycles", int'(echo_cycles), m_echo);
        check("hold_dist_cm", int'(dist_cm), exp_dist(m_echo));
    endtask

    task automatic pulse_start();
        @(posedge ACLK); #1 start = 1'b1;
        @(posedge ACLK); #1 start = 1'b0;
    endtask

    // kind 0: echo of w cycles, 1: no echo, 2: long echo (w > TMO),
    // 3: echo already high when the wait for the edge begins.
    task automatic run_meas(input int kind, input int w, input int wt, input bit pokes);
        int   n;
        int   r0;
        exp_t e;
        idle_checks();
        e.echo = (kind == 0) ? w : ((kind == 2) ? TMO : 0);
        e.tmo  = (kind != 0);
        sb_q.push_back(e);
        r0 = trig_rises;
        pulse_start();
        wait_trig(1'b1, 5, "trig_rise_wait");
        check("start_clears_timeout", int'(timeout), 0);
        if (kind == 3) echo_i = 1'b1;
        wait_trig(1'b0, TRIG + 5, "trig_fall_wait");
        if (kind == 0 || kind == 2) begin
            repeat (wt) @(posedge ACLK);
            #1 echo_i = 1'b1;
            for (int i = 0; i < w; i++) begin
                @(posedge ACLK);
                #1 start = (pokes && i == w / 2);
            end
            echo_i = 1'b0;
            start  = 1'b0;
            if (kind == 0) begin
                n = 0;
                do begin
                    @(negedge ACLK);
                    n++;
                end while (!done && n < 20);
                check("done_latency", n, 4 + EXTRA);
            end
        end else if (kind == 1) begin
            n = 0;
            while (!done && n < TMO + 100) begin
                @(negedge ACLK);
                n++;
            end
            check("noecho_done_cycles", n, TMO + EXTRA);
            n = 0;
            while (busy && n < HOLD + 20) begin
                @(negedge ACLK);
                n++;
            end
            check("holdoff_cycles", n, HOLD - EXTRA);
        end else begin
            repeat (20) @(posedge ACLK);
            #1 echo_i = 1'b0;
        end
        if (pokes) begin
            repeat (10) @(posedge ACLK);
            #1 start = 1'b1;
            @(posedge ACLK); #1 start = 1'b0;
        end
        wait_busy_low(3000);
        check("trig_count", trig_rises - r0, 1);
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=cycle_budget_exhausted required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r0;
        int   d0;
        int   n;
        int   rise_cyc[3];
        int   wts[3];
        exp_t e;

        ARESET = 1'b1; start = 1'b0; continuous = 1'b0; echo_i = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("rst_trig", int'(trig_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_echo_cycles", int'(echo_cycles), 0);
        check("rst_dist_cm", int'(dist_cm), 0);

        run_meas(0, 300, 20, 1'b0);   // single shot
        run_meas(1, 0, 0, 1'b0);      // no echo
        run_meas(2, 2000, 30, 1'b0);  // long echo saturates
        run_meas(0, $urandom_range(50, 400), $urandom_range(1, 200), 1'b0);
        run_meas(3, 0, 0, 1'b0);      // echo high before the wait starts
        run_meas(0, 1, 7, 1'b0);      // shortest echo
        run_meas(0, 200, 15, 1'b1);   // start pulses while busy

        // Start on the exact HOLDOFF->IDLE cycle is dropped.
        idle_checks();
        e.echo = 40; e.tmo = 1'b0;
        sb_q.push_back(e);
        r0 = trig_rises;
        pulse_start();
        wait_trig(1'b1, 5, "trig_rise_wait");
        wait_trig(1'b0, TRIG + 5, "trig_fall_wait");
        repeat (5) @(posedge ACLK);
        #1 echo_i = 1'b1;
        repeat (40) @(posedge ACLK);
        #1 echo_i = 1'b0;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!done && n < 20);
        check("done_latency", n, 4 + EXTRA);
        repeat (HOLD - 1 - EXTRA) @(posedge ACLK);
        #1 start = 1'b1;
        @(posedge ACLK); #1 start = 1'b0;
        repeat (40) @(posedge ACLK);
        #1;
        check("holdoff_exit_start_ignored", trig_rises - r0, 1);
        check("holdoff_exit_idle", int'(busy), 0);

        // Continuous mode: fixed period, one more result after deassert.
        idle_checks();
        r0 = trig_rises;
        d0 = dones;
        @(posedge ACLK); #1 continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_trig(1'b1, 2000, "cont_trig_rise_wait");
            rise_cyc[k] = cyc;
            if (k == 2) continuous = 1'b0;
            e.echo = 100; e.tmo = 1'b0;
            sb_q.push_back(e);
            wait_trig(1'b0, TRIG + 5, "cont_trig_fall_wait");
            wts[k] = $urandom_range(1, 60);
            repeat (wts[k]) @(posedge ACLK);
            #1 echo_i = 1'b1;
            repeat (100) @(posedge ACLK);
            #1 echo_i = 1'b0;
            if (k > 0)
                check("cont_trig_spacing", rise_cyc[k] - rise_cyc[k-1],
                      TRIG + wts[k-1] + 100 + 3 + HOLD + 1);
        end
        wait_busy_low(3000);
        repeat (300) @(posedge ACLK);
        #1;
        check("cont_trig_total", trig_rises - r0, 3);
        check("cont_done_total", dones - d0, 3);
        check("cont_stays_idle", int'(busy), 0);

        // Randomized measurements against the scoreboard.
        for (int i = 0; i < 10; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 8)       run_meas(0, $urandom_range(1, 900), $urandom_range(1, 300), 1'b0);
            else if (r == 8) run_meas(1, 0, 0, 1'b0);
            else             run_meas(3, 0, 0, 1'b0);
        end

        // Reset during the trigger pulse.
        idle_checks();
        r0 = trig_rises;
        d0 = dones;
        pulse_start();
        wait_trig(1'b1, 5, "trig_rise_wait");
        repeat (3) @(posedge ACLK);
        #2 ARESET = 1'b1;
        #1;
        check("arst_trig_async", int'(trig_o), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_timeout", int'(timeout), 0);
        check("arst_echo_cycles", int'(echo_cycles), 0);
        check("arst_dist_cm", int'(dist_cm), 0);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (1200) @(posedge ACLK);
        #1;
        check("arst_no_done", dones - d0, 0);
        check("arst_trig_count", trig_rises - r0, 1);
        check("arst_idle", int'(busy), 0);
        check("sb_queue_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
